// File: rtl/usb_tx_serializer_if.sv
// rtl/usb_tx_serializer_if.sv - byte-in / bit-out handshake bundle for the USB TX serializer
//
// Purpose: groups the upstream byte handshake, the downstream encoder bit
// handshake and the packet status flags of usb_tx_serializer.
// Ports (signals):
//   byte_in[7:0], byte_valid, byte_last  : packet byte from the source
//   byte_ready                           : holding register empty
//   bit_out, bit_valid, bit_last         : current bit presented to the JK encoder
//   bit_ack                              : encoder consumed the current bit
//   done, underrun, busy                 : packet status
// Modports: master = source/encoder side, slave = serializer side.
interface usb_tx_serializer_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_last;
  logic       bit_ack;
  logic       done;
  logic       underrun;
  logic       busy;

  modport master (
    output byte_in, byte_valid, byte_last, bit_ack,
    input  byte_ready, bit_out, bit_valid, bit_last, done, underrun, busy
  );

  modport slave (
    input  byte_in, byte_valid, byte_last, bit_ack,
    output byte_ready, bit_out, bit_valid, bit_last, done, underrun, busy
  );
endinterface

// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - LSB-first USB bit serializer with bit stuffing
//
// Purpose: takes packet bytes through a one-entry holding register, shifts
// them out LSB first to a JK encoder and inserts a 0 stuff bit after every
// run of STUFF_LEN consecutive 1 data bits (run tracked across byte
// boundaries within a packet).
// Ports:
//   clk36  : clock, rising edge
//   reset  : asynchronous, active-high
//   io     : usb_tx_serializer_if.slave (byte handshake, bit handshake, status)
module usb_tx_serializer #(
  parameter int STUFF_LEN = 6
) (
  input  logic               clk36,
  input  logic               reset,
  usb_tx_serializer_if.slave io
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_STUFF, S_WAIT} state_e;

  localparam logic [2:0] STUFF_CNT = 3'(STUFF_LEN);
  localparam logic [2:0] STUFF_PRE = 3'(STUFF_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_full_q, hold_full_d;
  logic       hold_last_q, hold_last_d;
  logic [7:0] shift_q, shift_d;
  logic       shift_last_q, shift_last_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] ones_q, ones_d;
  logic       done_q, done_d;
  logic       underrun_q, underrun_d;

  logic [2:0] ones_inc;
  logic       load;
  logic       byte_end;

  assign ones_inc = shift_q[0] ? ones_q + 3'd1 : 3'd0;

  always_ff @(posedge clk36 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_data_q  <= 8'd0;
      hold_full_q  <= 1'b0;
      hold_last_q  <= 1'b0;
      shift_q      <= 8'd0;
      shift_last_q <= 1'b0;
      bit_cnt_q    <= 3'd0;
      ones_q       <= 3'd0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_full_q  <= hold_full_d;
      hold_last_q  <= hold_last_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_full_d  = hold_full_q;
    hold_last_d  = hold_last_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    done_d       = 1'b0;
    underrun_d   = 1'b0;
    load         = 1'b0;
    byte_end     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          load      = 1'b1;
          bit_cnt_d = 3'd0;
          ones_d    = 3'd0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (io.bit_ack) begin
          // The data bit is consumed here even if a stuff bit follows; the
          // wrapped bit count (0) then marks a pending byte end in STUFF.
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (ones_inc == STUFF_CNT) begin
            ones_d  = 3'd0;
            state_d = S_STUFF;
          end else begin
            ones_d   = ones_inc;
            byte_end = (bit_cnt_q == 3'd7);
          end
        end
      end
      S_STUFF: begin
        if (io.bit_ack) begin
          byte_end = (bit_cnt_q == 3'd0);
          state_d  = S_SEND;
        end
      end
      S_WAIT: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_end) begin
      if (shift_last_q) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else if (hold_full_q) begin
        load    = 1'b1;
        state_d = S_SEND;
      end else begin
        state_d    = S_WAIT;
        underrun_d = 1'b1;
      end
    end

    // Load needs a full holding register, accept needs an empty one, so the
    // two never collide on the same edge.
    if (load) begin
      shift_d      = hold_data_q;
      shift_last_d = hold_last_q;
      hold_full_d  = 1'b0;
    end else if (io.byte_valid && !hold_full_q) begin
      hold_data_d = io.byte_in;
      hold_last_d = io.byte_last;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    io.byte_ready = !hold_full_q;
    io.bit_valid  = 1'b0;
    io.bit_out    = 1'b0;
    io.bit_last   = 1'b0;
    io.done       = done_q;
    io.underrun   = underrun_q;
    io.busy       = (state_q != S_IDLE);
    case (state_q)
      S_SEND: begin
        io.bit_valid = 1'b1;
        io.bit_out   = shift_q[0];
        // Final data bit is only last when it does not trigger a stuff bit.
        io.bit_last  = shift_last_q && (bit_cnt_q == 3'd7) &&
                       !(shift_q[0] && (ones_q == STUFF_PRE));
      end
      S_STUFF: begin
        io.bit_valid = 1'b1;
        io.bit_last  = shift_last_q && (bit_cnt_q == 3'd0);
      end
      default: ;
    endcase
  end

endmodule
